cpu_cmd_sequencer: RTL and testbench

Synthesizable host-command sequencer for the FPGA build of the 8-bit CPU. It accepts a byte stream of single-letter debug commands from a UART RX stream and drives the CPU's control word, bus and address overrides, and clk/iclk pulses. It returns read-back data over a UART TX stream. It sits between the UART core and the cpu instance, replacing the simulation-only command loop.

---
 rtl/cpu_cmd_pkg.sv | 46 ++++
 rtl/cmd_tx_shifter.sv | 45 ++++
 rtl/cpu_cmd_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_cpu_cmd_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_cmd_pkg.sv
// rtl/cpu_cmd_pkg.sv - command codes, states and helpers for the host-command sequencer
package cpu_cmd_pkg;

    localparam logic [7:0] CMD_IDENT    = 8'h49; // 'I'
    localparam logic [7:0] CMD_ADDR     = 8'h41; // 'A'
    localparam logic [7:0] CMD_BUS      = 8'h42; // 'B'
    localparam logic [7:0] CMD_MICRO    = 8'h4D; // 'M'
    localparam logic [7:0] CMD_OVERRIDE = 8'h4F; // 'O'
    localparam logic [7:0] CMD_RD_ADDR  = 8'h61; // 'a'
    localparam logic [7:0] CMD_RD_BUS   = 8'h62; // 'b'
    localparam logic [7:0] CMD_RD_FLAGS = 8'h73; // 's'
    localparam logic [7:0] CMD_FLOAT    = 8'h66; // 'f'
    localparam logic [7:0] CMD_NOP      = 8'h4E; // 'N'
    localparam logic [7:0] CMD_CLK      = 8'h63; // 'c'
    localparam logic [7:0] CMD_ICLK     = 8'h43; // 'C'
    localparam logic [7:0] CMD_TICK     = 8'h54; // 'T'
    localparam logic [7:0] CMD_TIMEOUT  = 8'hFF;

    localparam int TX_BYTES = 6;
    localparam int TX_BITS  = 8 * TX_BYTES;

    // Identification string, first character in the least significant byte
    localparam int                 ID_LEN = 6;
    localparam logic [TX_BITS-1:0] ID_STR = 48'h4D56_6167_7046; // "FpgaVM"

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_SEND,
        ST_CLK_HI,
        ST_GAP,
        ST_ICLK_HI
    } state_t;

    // Number of argument bytes that follow a command byte
    function automatic logic [2:0] arg_len(input logic [7:0] cmd);
        case (cmd)
            CMD_ADDR:     arg_len = 3'd2;
            CMD_BUS:      arg_len = 3'd1;
            CMD_MICRO:    arg_len = 3'd4;
            CMD_OVERRIDE: arg_len = 3'd4;
            default:      arg_len = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_tx_shifter.sv
// rtl/cmd_tx_shifter.sv - byte-serial response shifter with valid/ready handshake
module cmd_tx_shifter
    import cpu_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [TX_BITS-1:0] i_data,
    input  logic [2:0]         i_count,
    output logic [7:0]         o_tdata,
    output logic               o_tvalid,
    input  logic               i_tready,
    output logic               o_done
);

    logic [TX_BITS-1:0] r_buf;
    logic [2:0]         r_left;
    logic               r_valid;
    logic               w_xfer;

    assign w_xfer   = r_valid && i_tready;
    assign o_done   = w_xfer && (r_left == 3'd1);
    assign o_tdata  = r_buf[7:0];
    assign o_tvalid = r_valid;

    // Load a response, then shift one byte out per completed handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_left  <= 3'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_data;
            r_left  <= i_count;
            r_valid <= (i_count != 3'd0);
        end else if (w_xfer) begin
            r_buf  <= {8'h00, r_buf[TX_BITS-1:8]};
            r_left <= r_left - 3'd1;
            if (r_left == 3'd1) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// rtl/cpu_cmd_sequencer.sv - host debug-command sequencer driving the 8-bit CPU
module cpu_cmd_sequencer
    import cpu_cmd_pkg::*;
#(
    parameter logic [31:0] DEFAULT_CW   = 32'h0000_0000,
    parameter int          PULSE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  main_bus_out,
    output logic        main_bus_oe,
    input  logic [7:0]  main_bus_in,
    output logic [15:0] addr_out,
    output logic        addr_oe,
    input  logic [15:0] addr_in,
    input  logic [3:0]  flags_in,
    output logic [31:0] control_word,
    output logic        cpu_clk,
    output logic        cpu_iclk,
    output logic        cpu_rst,
    output logic        unknown_cmd
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_arg;
    logic [2:0]  r_cnt;
    logic [7:0]  r_cmd;
    logic        r_tick;
    logic [7:0]  r_pulse_cnt;
    logic        r_float_pend;
    logic        r_unknown;
    logic        r_cpu_rst;
    logic        r_cpu_clk;
    logic        r_cpu_iclk;
    logic [31:0] r_cw;
    logic [15:0] r_addr_out;
    logic        r_addr_oe;
    logic [7:0]  r_bus_out;
    logic        r_bus_oe;

    logic               w_accept;
    logic               w_tx_load;
    logic               w_tx_done;
    logic [TX_BITS-1:0] w_tx_bytes;
    logic [2:0]         w_tx_count;
    logic               w_arg_start;
    logic               w_arg_shift;
    logic               w_arg_done;
    logic               w_oe_clear;
    logic               w_float_req;
    logic               w_unknown;
    logic               w_pulse_load;
    logic               w_tick_nxt;
    logic [2:0]         w_len;
    logic [5:0]         w_shamt;
    logic [31:0]        w_arg_new;
    logic [31:0]        w_arg_final;

    assign rx_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_ARG));
    assign w_accept = rx_valid && rx_ready;

    // Bytes arrive LSB first; shorter arguments are right-aligned after the last byte
    assign w_len       = arg_len(r_cmd);
    assign w_shamt     = {3'd4 - w_len, 3'b000};
    assign w_arg_new   = {rx_data, r_arg[31:8]};
    assign w_arg_final = w_arg_new >> w_shamt;

    assign main_bus_out = r_bus_out;
    assign main_bus_oe  = r_bus_oe;
    assign addr_out     = r_addr_out;
    assign addr_oe      = r_addr_oe;
    assign control_word = r_cw;
    assign cpu_clk      = r_cpu_clk;
    assign cpu_iclk     = r_cpu_iclk;
    assign cpu_rst      = r_cpu_rst;
    assign unknown_cmd  = r_unknown;

    cmd_tx_shifter u_tx (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tx_load),
        .i_data   (w_tx_bytes),
        .i_count  (w_tx_count),
        .o_tdata  (tx_data),
        .o_tvalid (tx_valid),
        .i_tready (tx_ready),
        .o_done   (w_tx_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command decode, argument sequencing and pulse timing
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_load    = 1'b0;
        w_tx_bytes   = '0;
        w_tx_count   = 3'd0;
        w_arg_start  = 1'b0;
        w_arg_shift  = 1'b0;
        w_arg_done   = 1'b0;
        w_oe_clear   = 1'b0;
        w_float_req  = 1'b0;
        w_unknown    = 1'b0;
        w_pulse_load = 1'b0;
        w_tick_nxt   = r_tick;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (rx_data)
                        CMD_IDENT: begin
                            w_tx_load   = 1'b1;
                            w_tx_bytes  = ID_STR;
                            w_tx_count  = 3'(ID_LEN);
                            w_state_nxt = ST_SEND;
                        end
                        CMD_ADDR, CMD_BUS, CMD_MICRO: begin
                            w_arg_start = 1'b1;
                            w_state_nxt = ST_ARG;
                        end
                        CMD_OVERRIDE: begin
                            w_arg_start = 1'b1;
                            w_oe_clear  = 1'b1;
                            w_state_nxt = ST_ARG;
                        end
                        CMD_RD_ADDR: begin
                            w_tx_load   = 1'b1;
                            w_tx_bytes  = {32'h0, addr_in};
                            w_tx_count  = 3'd2;
                            w_state_nxt = ST_SEND;
                        end
                        CMD_RD_BUS: begin
                            w_tx_load   = 1'b1;
                            w_tx_bytes  = {40'h0, main_bus_in};
                            w_tx_count  = 3'd1;
                            w_state_nxt = ST_SEND;
                        end
                        CMD_RD_FLAGS: begin
                            w_tx_load   = 1'b1;
                            w_tx_bytes  = {40'h0, 4'h0, flags_in};
                            w_tx_count  = 3'd1;
                            w_state_nxt = ST_SEND;
                        end
                        CMD_FLOAT: begin
                            w_float_req = 1'b1;
                        end
                        CMD_NOP, CMD_TIMEOUT: begin
                            w_state_nxt = ST_IDLE;
                        end
                        CMD_CLK: begin
                            w_pulse_load = 1'b1;
                            w_tick_nxt   = 1'b0;
                            w_state_nxt  = ST_CLK_HI;
                        end
                        CMD_ICLK: begin
                            w_pulse_load = 1'b1;
                            w_state_nxt  = ST_ICLK_HI;
                        end
                        CMD_TICK: begin
                            w_pulse_load = 1'b1;
                            w_tick_nxt   = 1'b1;
                            w_state_nxt  = ST_CLK_HI;
                        end
                        default: begin
                            w_unknown = 1'b1;
                        end
                    endcase
                end
            end
            ST_ARG: begin
                if (w_accept) begin
                    w_arg_shift = 1'b1;
                    if (r_cnt == 3'd1) begin
                        w_arg_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_SEND: begin
                if (w_tx_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLK_HI: begin
                if (r_pulse_cnt == 8'd0) begin
                    if (r_tick) begin
                        w_pulse_load = 1'b1;
                        w_state_nxt  = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_pulse_cnt == 8'd0) begin
                    w_pulse_load = 1'b1;
                    w_state_nxt  = ST_ICLK_HI;
                end
            end
            ST_ICLK_HI: begin
                if (r_pulse_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Argument shift register and remaining-byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arg <= 32'h0;
            r_cnt <= 3'd0;
            r_cmd <= 8'h00;
        end else if (w_arg_start) begin
            r_cmd <= rx_data;
            r_cnt <= arg_len(rx_data);
        end else if (w_arg_shift) begin
            r_arg <= w_arg_new;
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Pulse phase counter; clock outputs follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_cnt <= 8'd0;
            r_tick      <= 1'b0;
            r_cpu_clk   <= 1'b0;
            r_cpu_iclk  <= 1'b0;
        end else begin
            r_tick     <= w_tick_nxt;
            r_cpu_clk  <= (w_state_nxt == ST_CLK_HI);
            r_cpu_iclk <= (w_state_nxt == ST_ICLK_HI);
            if (w_pulse_load) begin
                r_pulse_cnt <= PULSE_LAST;
            end else if (r_pulse_cnt != 8'd0) begin
                r_pulse_cnt <= r_pulse_cnt - 8'd1;
            end
        end
    end

    // CPU override targets, updated on the final argument byte or an oe release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cw       <= DEFAULT_CW;
            r_addr_out <= 16'h0;
            r_addr_oe  <= 1'b0;
            r_bus_out  <= 8'h00;
            r_bus_oe   <= 1'b0;
        end else begin
            if (w_oe_clear || r_float_pend) begin
                r_addr_oe <= 1'b0;
                r_bus_oe  <= 1'b0;
            end
            if (w_arg_done) begin
                case (r_cmd)
                    CMD_ADDR: begin
                        r_addr_out <= w_arg_final[15:0];
                        r_addr_oe  <= 1'b1;
                    end
                    CMD_BUS: begin
                        r_bus_out <= w_arg_final[7:0];
                        r_bus_oe  <= 1'b1;
                    end
                    default: begin
                        r_cw <= w_arg_final;
                    end
                endcase
            end
        end
    end

    // CPU reset tail, unknown-command pulse and deferred oe release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rst    <= 1'b1;
            r_unknown    <= 1'b0;
            r_float_pend <= 1'b0;
        end else begin
            r_cpu_rst    <= 1'b0;
            r_unknown    <= w_unknown;
            r_float_pend <= w_float_req;
        end
    end

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// tb/tb_cpu_cmd_sequencer.sv - self-checking bench for cpu_cmd_sequencer
module tb_cpu_cmd_sequencer;

    localparam logic [31:0] DEF_CW = 32'hCAFE_0001;
    localparam int          P      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  main_bus_out;
    logic        main_bus_oe;
    logic [7:0]  main_bus_in = 8'h00;
    logic [15:0] addr_out;
    logic        addr_oe;
    logic [15:0] addr_in = 16'h0000;
    logic [3:0]  flags_in = 4'h0;
    logic [31:0] control_word;
    logic        cpu_clk;
    logic        cpu_iclk;
    logic        cpu_rst;
    logic        unknown_cmd;

    cpu_cmd_sequencer #(.DEFAULT_CW(DEF_CW), .PULSE_CYCLES(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .main_bus_out (main_bus_out),
        .main_bus_oe  (main_bus_oe),
        .main_bus_in  (main_bus_in),
        .addr_out     (addr_out),
        .addr_oe      (addr_oe),
        .addr_in      (addr_in),
        .flags_in     (flags_in),
        .control_word (control_word),
        .cpu_clk      (cpu_clk),
        .cpu_iclk     (cpu_iclk),
        .cpu_rst      (cpu_rst),
        .unknown_cmd  (unknown_cmd)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Transaction-level model: mode 0 idle, 1 collecting argument, 2 responding, 3 pulsing
    int          m_mode    = 0;
    logic [7:0]  m_tx[$];
    logic [7:0]  m_args[$];
    logic [7:0]  m_cmd     = 8'h00;
    int          m_need    = 0;
    int          m_t0      = 0;
    int          m_kind    = 0;   // 0 'c', 1 'T', 2 'C'
    logic [15:0] m_addr    = 16'h0;
    logic        m_addr_oe = 1'b0;
    logic [7:0]  m_bus     = 8'h00;
    logic        m_bus_oe  = 1'b0;
    logic [31:0] m_cw      = DEF_CW;
    logic        m_float   = 1'b0;
    logic        m_unk     = 1'b0;
    logic        m_cpu_rst = 1'b1;

    logic [7:0]  got_tx[$];
    int          clk_hi_cnt  = 0;
    int          iclk_hi_cnt = 0;
    int          unk_cnt     = 0;
    int          tx_mode     = 0; // 0 always ready, 1 toggling, 2 stalled
    string       id_s = "FpgaVM";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model by this cycle's events
    always @(negedge clk) begin
        logic        acc;
        logic        hs;
        logic        e_clk;
        logic        e_iclk;
        logic [31:0] v;
        int          d;
        int          mode0;
        d      = cyc - m_t0;
        e_clk  = (m_mode == 3) && (m_kind != 2) && (d >= 1) && (d <= P);
        e_iclk = (m_mode == 3) && (((m_kind == 2) && (d >= 1) && (d <= P)) ||
                                   ((m_kind == 1) && (d >= 2*P+1) && (d <= 3*P)));
        chk("rx_ready", rx_ready, !rst && (m_mode <= 1));
        chk("tx_valid", tx_valid, m_tx.size() != 0);
        if (tx_valid && m_tx.size() != 0) chk("tx_data", tx_data, m_tx[0]);
        chk("addr_out", addr_out, m_addr);
        chk("addr_oe", addr_oe, m_addr_oe);
        chk("main_bus_out", main_bus_out, m_bus);
        chk("main_bus_oe", main_bus_oe, m_bus_oe);
        chk("control_word", control_word, m_cw);
        chk("cpu_clk", cpu_clk, e_clk);
        chk("cpu_iclk", cpu_iclk, e_iclk);
        chk("clk_excl", cpu_clk & cpu_iclk, 1'b0);
        chk("cpu_rst", cpu_rst, m_cpu_rst);
        chk("unknown_cmd", unknown_cmd, m_unk);
        clk_hi_cnt  += int'(cpu_clk);
        iclk_hi_cnt += int'(cpu_iclk);
        unk_cnt     += int'(unknown_cmd);

        acc   = rx_valid && rx_ready;
        hs    = tx_valid && tx_ready;
        mode0 = m_mode;
        if (hs) got_tx.push_back(tx_data);
        if (rst) begin
            m_mode = 0; m_tx.delete(); m_args.delete();
            m_addr = 16'h0; m_addr_oe = 1'b0; m_bus = 8'h00; m_bus_oe = 1'b0;
            m_cw = DEF_CW; m_float = 1'b0; m_unk = 1'b0; m_cpu_rst = 1'b1;
        end else begin
            m_cpu_rst = 1'b0;
            m_unk     = 1'b0;
            if (m_float) begin
                m_addr_oe = 1'b0; m_bus_oe = 1'b0; m_float = 1'b0;
            end
            if (hs && m_tx.size() != 0) begin
                void'(m_tx.pop_front());
                if (m_tx.size() == 0 && m_mode == 2) m_mode = 0;
            end
            if (m_mode == 3 && d >= ((m_kind == 1) ? 3*P : P)) m_mode = 0;
            if (acc && mode0 == 0) begin
                case (rx_data)
                    "I": begin
                        for (int i = 0; i < 6; i++) m_tx.push_back(id_s[i]);
                        m_mode = 2;
                    end
                    "A": begin m_cmd = rx_data; m_need = 2; m_args.delete(); m_mode = 1; end
                    "B": begin m_cmd = rx_data; m_need = 1; m_args.delete(); m_mode = 1; end
                    "M": begin m_cmd = rx_data; m_need = 4; m_args.delete(); m_mode = 1; end
                    "O": begin
                        m_cmd = rx_data; m_need = 4; m_args.delete(); m_mode = 1;
                        m_addr_oe = 1'b0; m_bus_oe = 1'b0;
                    end
                    "a": begin m_tx.push_back(addr_in[7:0]); m_tx.push_back(addr_in[15:8]); m_mode = 2; end
                    "b": begin m_tx.push_back(main_bus_in); m_mode = 2; end
                    "s": begin m_tx.push_back({4'h0, flags_in}); m_mode = 2; end
                    "f": m_float = 1'b1;
                    "N", 8'hFF: m_mode = 0;
                    "c": begin m_mode = 3; m_kind = 0; m_t0 = cyc; end
                    "T": begin m_mode = 3; m_kind = 1; m_t0 = cyc; end
                    "C": begin m_mode = 3; m_kind = 2; m_t0 = cyc; end
                    default: m_unk = 1'b1;
                endcase
            end else if (acc && mode0 == 1) begin
                m_args.push_back(rx_data);
                if (m_args.size() == m_need) begin
                    v = 32'h0;
                    for (int i = 0; i < m_need; i++) v = v | (32'(m_args[i]) << (8*i));
                    if (m_cmd == "A") begin
                        m_addr = v[15:0]; m_addr_oe = 1'b1;
                    end else if (m_cmd == "B") begin
                        m_bus = v[7:0]; m_bus_oe = 1'b1;
                    end else begin
                        m_cw = v;
                    end
                    m_mode = 0;
                end
            end
        end
        cyc++;
    end

    // TX ready pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_mode == 1)      tx_ready = !tx_ready;
            else if (tx_mode == 2) tx_ready = 1'b0;
            else                   tx_ready = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, required acceptance within 300 cycles", b);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready && !tx_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL idle_timeout: sequencer still busy, required idle within 300 cycles");
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_id [6];
        int c0;
        int i0;
        int u0;
        exp_id = '{8'h46, 8'h70, 8'h67, 8'h61, 8'h56, 8'h4D};

        // Reset for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cw", control_word, DEF_CW);
        chk("rst_oe", {addr_oe, main_bus_oe}, 2'b00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("cpu_rst_hold", cpu_rst, 1'b1);
        @(negedge clk);
        chk("cpu_rst_release", cpu_rst, 1'b0);
        @(posedge clk);
        #1;

        // Address override then read-back
        addr_in = 16'h1234;
        send_byte("A"); send_byte(8'h34); send_byte(8'h12);
        chk("A_addr_out", addr_out, 16'h1234);
        chk("A_addr_oe", addr_oe, 1'b1);
        got_tx.delete();
        send_byte("a");
        wait_idle();
        chk("a_count", got_tx.size(), 2);
        chk("a_byte0", got_tx[0], 8'h34);
        chk("a_byte1", got_tx[1], 8'h12);
        addr_in = 16'hBEEF;
        send_byte("a");
        wait_idle();

        // Bus override, then full override release and control word load
        send_byte("B"); send_byte(8'hA5);
        chk("B_bus_out", main_bus_out, 8'hA5);
        chk("B_bus_oe", main_bus_oe, 1'b1);
        send_byte("O");
        chk("O_oe_clear", {addr_oe, main_bus_oe}, 2'b00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        chk("O_cw_partial", control_word, DEF_CW);
        send_byte(8'h12);
        chk("O_cw", control_word, 32'h1234_5678);
        send_byte("M"); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("M_cw", control_word, 32'hDEAD_BEEF);

        // Clock pulses
        c0 = clk_hi_cnt; i0 = iclk_hi_cnt;
        send_byte("T");
        wait_idle();
        chk("T_clk_cycles", clk_hi_cnt - c0, P);
        chk("T_iclk_cycles", iclk_hi_cnt - i0, P);
        c0 = clk_hi_cnt; i0 = iclk_hi_cnt;
        send_byte("c");
        wait_idle();
        chk("c_clk_cycles", clk_hi_cnt - c0, P);
        chk("c_iclk_cycles", iclk_hi_cnt - i0, 0);
        send_byte("C");
        wait_idle();
        chk("C_iclk_cycles", iclk_hi_cnt - i0, P);

        // Identification string with a toggling ready
        tx_mode = 1;
        got_tx.delete();
        send_byte("I");
        wait_idle();
        tx_mode = 0;
        chk("I_count", got_tx.size(), 6);
        for (int i = 0; i < 6; i++) chk("I_byte", got_tx[i], exp_id[i]);

        // Snapshot survives bus changes while the response is stalled
        main_bus_in = 8'h5A;
        tx_mode = 2;
        got_tx.delete();
        send_byte("b");
        main_bus_in = 8'hFF;
        idle_cycles(4);
        tx_mode = 0;
        wait_idle();
        chk("b_count", got_tx.size(), 1);
        chk("b_snapshot", got_tx[0], 8'h5A);
        flags_in = 4'hB;
        got_tx.delete();
        send_byte("s");
        wait_idle();
        chk("s_flags", got_tx[0], 8'h0B);

        // Float, no-ops and an unknown byte
        send_byte("B"); send_byte(8'h11);
        send_byte("A"); send_byte(8'hEF); send_byte(8'hBE);
        chk("pre_f_oe", {addr_oe, main_bus_oe}, 2'b11);
        send_byte("f");
        idle_cycles(3);
        chk("f_oe_clear", {addr_oe, main_bus_oe}, 2'b00);
        send_byte("N");
        send_byte(8'hFF);
        u0 = unk_cnt;
        got_tx.delete();
        send_byte("Z");
        idle_cycles(3);
        chk("Z_unknown_pulses", unk_cnt - u0, 1);
        chk("Z_no_tx", got_tx.size(), 0);

        // Reset in the middle of an argument
        send_byte("M"); send_byte(8'h01);
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        chk("rst_mid_cw", control_word, DEF_CW);
        main_bus_in = 8'h3C;
        got_tx.delete();
        send_byte("b");
        wait_idle();
        chk("rst_mid_b_count", got_tx.size(), 1);
        chk("rst_mid_b_data", got_tx[0], 8'h3C);
        chk("rst_mid_cw_after", control_word, DEF_CW);

        idle_cycles(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
